// File: rtl/reg_select_pkg.sv
// Shared types and constants for the register-select decoder: FSM states,
// the default register map and the code validity check.
package reg_select_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DRIVE = 2'd2
    } state_t;

    // Codes 2 and 3 are unmapped in the default register file.
    localparam logic [11:0] DEFAULT_VALID_MASK = 12'hFF9;

    localparam logic [3:0] SEL_SP  = 4'd1;
    localparam logic [3:0] SEL_MAR = 4'd4;
    localparam logic [3:0] SEL_MDR = 4'd5;
    localparam logic [3:0] SEL_PR1 = 4'd6;
    localparam logic [3:0] SEL_PR2 = 4'd7;
    localparam logic [3:0] SEL_PR3 = 4'd8;
    localparam logic [3:0] SEL_COL = 4'd9;
    localparam logic [3:0] SEL_ROW = 4'd10;
    localparam logic [3:0] SEL_R1  = 4'd11;
    localparam logic [3:0] SEL_R2  = 4'd12;

    // Valid iff 1 <= code <= n_out and the matching mask bit is set.
    function automatic logic code_valid(input int unsigned code,
                                        input int unsigned n_out,
                                        input logic [63:0] mask);
        logic v;
        v = 1'b0;
        for (int unsigned i = 0; i < 64; i++) begin
            if (mask[i] && (i < n_out) && (code == i + 1)) begin
                v = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/reg_sel_onehot.sv
// Combinational select-code to one-hot decoder with a validity flag;
// unmapped codes and code 0 decode to all-zero.
module reg_sel_onehot
    import reg_select_pkg::*;
#(
    parameter int               SEL_W      = 4,
    parameter int               N_OUT      = 12,
    parameter logic [N_OUT-1:0] VALID_MASK = N_OUT'(DEFAULT_VALID_MASK)
) (
    input  logic [SEL_W-1:0] code,
    output logic [N_OUT-1:0] onehot,
    output logic             valid
);

    localparam int NW    = $clog2(N_OUT + 1);
    localparam int CMP_W = (SEL_W > NW) ? SEL_W : NW;

    logic [CMP_W-1:0] code_ext;
    assign code_ext = CMP_W'(code);

    genvar gi;
    generate
        for (gi = 0; gi < N_OUT; gi++) begin : g_bit
            assign onehot[gi] = VALID_MASK[gi] && (code_ext == CMP_W'(gi + 1));
        end
    endgenerate

    assign valid = code_valid(32'(code), N_OUT, 64'(VALID_MASK));

endmodule

// File: rtl/reg_select_decoder.sv
// Registered bus-destination decoder: latches a select code, then drives a
// one-hot register load enable for HOLD cycles (or until clr when STICKY).
module reg_select_decoder
    import reg_select_pkg::*;
#(
    parameter int               SEL_W      = 4,
    parameter int               N_OUT      = 12,
    parameter logic [N_OUT-1:0] VALID_MASK = N_OUT'(DEFAULT_VALID_MASK),
    parameter int               HOLD       = 1,
    parameter int               STICKY     = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] sel,
    input  logic             en_op,
    input  logic             en_out,
    input  logic             clr,
    output logic [N_OUT-1:0] out,
    output logic             busy,
    output logic             err
);

    localparam int               CNT_W    = $clog2(HOLD + 1);
    localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   code_reg, code_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [N_OUT-1:0]   out_reg, out_next;
    logic               err_reg, err_next;

    logic [N_OUT-1:0]   sel_onehot, lat_onehot;
    logic               sel_valid, lat_valid;

    reg_sel_onehot #(.SEL_W(SEL_W), .N_OUT(N_OUT), .VALID_MASK(VALID_MASK)) u_dec_sel (
        .code   (sel),
        .onehot (sel_onehot),
        .valid  (sel_valid)
    );

    reg_sel_onehot #(.SEL_W(SEL_W), .N_OUT(N_OUT), .VALID_MASK(VALID_MASK)) u_dec_lat (
        .code   (code_reg),
        .onehot (lat_onehot),
        .valid  (lat_valid)
    );

    always_comb begin
        state_next = state_reg;
        code_next  = code_reg;
        cnt_next   = cnt_reg;
        out_next   = out_reg;
        err_next   = 1'b0;

        if (clr) begin
            state_next = IDLE;
            code_next  = '0;
            cnt_next   = '0;
            out_next   = '0;
        end else begin
            case (state_reg)
                IDLE, ARMED: begin
                    if (en_op && en_out) begin
                        // Same-cycle pair bypasses the latch straight to the output.
                        if (sel_valid) begin
                            state_next = DRIVE;
                            code_next  = sel;
                            cnt_next   = HOLD_CNT;
                            out_next   = sel_onehot;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (en_op) begin
                        if (sel_valid) begin
                            state_next = ARMED;
                            code_next  = sel;
                        end else begin
                            err_next = 1'b1;
                        end
                    end else if (en_out) begin
                        if (state_reg == ARMED && lat_valid) begin
                            state_next = DRIVE;
                            cnt_next   = HOLD_CNT;
                            out_next   = lat_onehot;
                        end else begin
                            err_next = 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    if (en_op || en_out) begin
                        err_next = 1'b1;
                    end
                    if (STICKY == 0) begin
                        if (cnt_reg <= CNT_W'(1)) begin
                            state_next = IDLE;
                            cnt_next   = '0;
                            out_next   = '0;
                        end else begin
                            cnt_next = cnt_reg - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    out_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            code_reg  <= '0;
            cnt_reg   <= '0;
            out_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            code_reg  <= code_next;
            cnt_reg   <= cnt_next;
            out_reg   <= out_next;
            err_reg   <= err_next;
        end
    end

    assign out  = out_reg;
    assign busy = (state_reg != IDLE);
    assign err  = err_reg;

endmodule

// File: tb/tb_reg_select_decoder.sv
// Directed bench: a vector table on the default-parameter decoder plus
// hand sequences for HOLD=3, STICKY and asynchronous reset mid-drive.
module tb_reg_select_decoder;
    import reg_select_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  sel;
    logic        en_op, en_out, clr;

    logic [11:0] out_d0, out_d1, out_d2, out_d3;
    logic        busy_d0, busy_d1, busy_d2, busy_d3;
    logic        err_d0, err_d1, err_d2, err_d3;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reg_select_decoder u_d0 (
        .clk(clk), .rst(rst), .sel(sel), .en_op(en_op), .en_out(en_out), .clr(clr),
        .out(out_d0), .busy(busy_d0), .err(err_d0)
    );
    reg_select_decoder #(.HOLD(3)) u_d1 (
        .clk(clk), .rst(rst), .sel(sel), .en_op(en_op), .en_out(en_out), .clr(clr),
        .out(out_d1), .busy(busy_d1), .err(err_d1)
    );
    reg_select_decoder #(.STICKY(1)) u_d2 (
        .clk(clk), .rst(rst), .sel(sel), .en_op(en_op), .en_out(en_out), .clr(clr),
        .out(out_d2), .busy(busy_d2), .err(err_d2)
    );
    reg_select_decoder #(.HOLD(4)) u_d3 (
        .clk(clk), .rst(rst), .sel(sel), .en_op(en_op), .en_out(en_out), .clr(clr),
        .out(out_d3), .busy(busy_d3), .err(err_d3)
    );

    typedef struct {
        logic        op;
        logic        drv;
        logic        c;
        logic [3:0]  s;
        logic [11:0] e_out;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic op, input logic drv, input logic c,
                                input logic [3:0] s, input logic [11:0] e_out,
                                input logic e_busy, input logic e_err);
        vec_t v;
        v.op = op; v.drv = drv; v.c = c; v.s = s;
        v.e_out = e_out; v.e_busy = e_busy; v.e_err = e_err;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic op, input logic drv, input logic c, input logic [3:0] s);
        en_op = op; en_out = drv; clr = c; sel = s;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 4'd0);
        #12;
        check("rst_out0", 32'(out_d0), 0);
        check("rst_busy0", 32'(busy_d0), 0);
        check("rst_err0", 32'(err_d0), 0);
        check("rst_out2", 32'(out_d2), 0);
        #4 rst = 1'b0;
        tick();

        // Expectations are the registered outputs one edge after each row's inputs.
        add(1, 0, 0, SEL_MDR, 12'h000, 1, 0);
        add(0, 1, 0, 4'd0,    12'h010, 1, 0);
        add(0, 0, 0, 4'd0,    12'h000, 0, 0);
        add(1, 0, 0, 4'd0,    12'h000, 0, 1);
        add(0, 0, 0, 4'd0,    12'h000, 0, 0);
        add(1, 0, 0, 4'd2,    12'h000, 0, 1);
        add(1, 0, 0, 4'd3,    12'h000, 0, 1);
        add(1, 0, 0, 4'd13,   12'h000, 0, 1);
        add(0, 1, 0, 4'd0,    12'h000, 0, 1);
        add(1, 0, 0, SEL_MAR, 12'h000, 1, 0);
        add(1, 0, 0, SEL_COL, 12'h000, 1, 0);
        add(0, 1, 0, 4'd0,    12'h100, 1, 0);
        add(0, 0, 0, 4'd0,    12'h000, 0, 0);
        add(1, 1, 0, SEL_R2,  12'h800, 1, 0);
        add(1, 1, 0, SEL_R2,  12'h000, 0, 1);
        add(1, 1, 0, 4'd2,    12'h000, 0, 1);
        add(1, 0, 0, SEL_PR1, 12'h000, 1, 0);
        add(1, 0, 0, 4'd3,    12'h000, 1, 1);
        add(0, 1, 0, 4'd0,    12'h020, 1, 0);
        add(0, 0, 0, 4'd0,    12'h000, 0, 0);
        add(1, 0, 0, SEL_PR2, 12'h000, 1, 0);
        add(0, 0, 1, 4'd0,    12'h000, 0, 0);
        add(0, 1, 0, 4'd0,    12'h000, 0, 1);
        add(0, 0, 0, 4'd0,    12'h000, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].op, vecs[i].drv, vecs[i].c, vecs[i].s);
            tick();
            check($sformatf("v%0d_out", i), 32'(out_d0), 32'(vecs[i].e_out));
            check($sformatf("v%0d_busy", i), 32'(busy_d0), 32'(vecs[i].e_busy));
            check($sformatf("v%0d_err", i), 32'(err_d0), 32'(vecs[i].e_err));
            $display("vec %0d: op=%0d out_en=%0d clr=%0d sel=%0d -> out=%03h busy=%0d err=%0d",
                     i, vecs[i].op, vecs[i].drv, vecs[i].c, vecs[i].s, out_d0, busy_d0, err_d0);
        end

        // HOLD=3, bypass pair with sel=12.
        set_in(0, 0, 1, 4'd0); tick();
        set_in(1, 1, 0, SEL_R2); tick();
        set_in(0, 0, 0, 4'd0);
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("hold3_out_t%0d", k), 32'(out_d1), 32'h800);
            check($sformatf("hold3_busy_t%0d", k), 32'(busy_d1), 1);
            tick();
        end
        check("hold3_out_t4", 32'(out_d1), 0);
        check("hold3_busy_t4", 32'(busy_d1), 0);
        $display("hold3: out=%03h busy=%0d after drive", out_d1, busy_d1);

        // STICKY: hold until clr, strobes during drive only raise err.
        set_in(0, 0, 1, 4'd0); tick();
        set_in(1, 1, 0, SEL_SP); tick();
        set_in(0, 0, 0, 4'd0);
        for (int k = 0; k < 20; k++) begin
            check($sformatf("sticky_out_c%0d", k), 32'(out_d2), 32'h001);
            tick();
        end
        set_in(1, 0, 0, SEL_MDR); tick();
        check("sticky_op_err", 32'(err_d2), 1);
        check("sticky_op_out", 32'(out_d2), 32'h001);
        set_in(0, 0, 1, 4'd0); tick();
        check("sticky_clr_out", 32'(out_d2), 0);
        check("sticky_clr_busy", 32'(busy_d2), 0);
        check("sticky_clr_err", 32'(err_d2), 0);
        $display("sticky: out=%03h busy=%0d after clr", out_d2, busy_d2);

        // HOLD=4: async reset in the second drive cycle.
        set_in(0, 0, 0, 4'd0); tick();
        set_in(1, 1, 0, SEL_COL); tick();
        set_in(0, 0, 0, 4'd0);
        check("arst_out_c1", 32'(out_d3), 32'h100);
        tick();
        check("arst_out_c2", 32'(out_d3), 32'h100);
        #2 rst = 1'b1;
        #1;
        check("arst_out_now", 32'(out_d3), 0);
        check("arst_busy_now", 32'(busy_d3), 0);
        #2 rst = 1'b0;
        set_in(1, 0, 0, SEL_ROW); tick();
        check("arst_armed_busy", 32'(busy_d3), 1);
        set_in(0, 1, 0, 4'd0); tick();
        set_in(0, 0, 0, 4'd0);
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("arst_post_out_t%0d", k), 32'(out_d3), 32'h200);
            tick();
        end
        check("arst_post_out_t5", 32'(out_d3), 0);
        check("arst_post_busy_t5", 32'(busy_d3), 0);
        $display("arst: out=%03h busy=%0d after post-reset drive", out_d3, busy_d3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
